list_fold_sink: RTL and testbench

Downstream consumer for the generated dataflow functions' list-output port. Starts the producing function, pulls elements one at a time over the req/ack/eol/value list handshake, and folds them into a signed sum, an element count and a running maximum. Reports completion with a done pulse, and flags a timeout if the producer stalls. Sits between a `dfd_*` function instance and board-level result/LED logic.

---
 rtl/h2v_list_pkg.sv | 11 +
 rtl/list_fold_acc.sv | 31 +++
 rtl/list_fold_sink.sv | 91 +++++++++
 tb/tb_list_fold_sink.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/h2v_list_pkg.sv
// h2v_list_pkg: shared state encoding, list handshake roles and width helpers for list consumers
package h2v_list_pkg;
  typedef enum logic [1:0] {IDLE, REQ, GAP, FINISH} list_state_t;
  localparam logic LIST_ELEM = 1'b0;
  localparam logic LIST_EOL = 1'b1;
  localparam logic LIST_REQ_ON = 1'b1;
  localparam logic LIST_ACK_ON = 1'b1;
  function automatic logic [63:0] most_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/list_fold_acc.sv
// list_fold_acc: signed sum, saturating count and running maximum of list elements
module list_fold_acc import h2v_list_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int SUM_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  clear,
  input  logic                  accumulate,
  input  logic [DATA_WIDTH-1:0] value,
  output logic [SUM_WIDTH-1:0]  sum,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [DATA_WIDTH-1:0] max
);
  localparam logic [DATA_WIDTH-1:0] MAX_INIT = DATA_WIDTH'(most_neg(DATA_WIDTH));
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      sum <= '0;
      count <= '0;
      max <= MAX_INIT;
    end else if (clear) begin
      sum <= '0;
      count <= '0;
      max <= MAX_INIT;
    end else if (accumulate) begin
      sum <= sum + SUM_WIDTH'($signed(value));
      count <= &count ? count : count + 1'b1;
      max <= $signed(value) > $signed(max) ? value : max;
    end
endmodule

// File: rtl/list_fold_sink.sv
// list_fold_sink: pulls a list from a producer over req/ack/eol and folds it into sum, count and max
module list_fold_sink import h2v_list_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int SUM_WIDTH = 16,
  parameter int CNT_WIDTH = 8,
  parameter int REQ_GAP = 0,
  parameter int TIMEOUT = 1024
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  start,
  output logic                  busy,
  output logic                  fn_ready,
  output logic                  list_req,
  input  logic                  list_ack,
  input  logic                  list_eol,
  input  logic [DATA_WIDTH-1:0] list_value,
  output logic [SUM_WIDTH-1:0]  result_sum,
  output logic [CNT_WIDTH-1:0]  result_count,
  output logic [DATA_WIDTH-1:0] result_max,
  output logic                  result_valid,
  output logic                  done,
  output logic                  timeout_err
);
  localparam int GW = $clog2(REQ_GAP + 2);
  localparam int TW = $clog2(TIMEOUT + 2);
  list_state_t state, nxt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] wait_cnt;
  logic aborted;
  logic gap_done;
  logic tmo_hit;
  logic accumulate;
  logic [SUM_WIDTH-1:0] acc_sum;
  logic [CNT_WIDTH-1:0] acc_count;
  logic [DATA_WIDTH-1:0] acc_max;
  assign fn_ready = state == REQ || state == GAP;
  assign list_req = state == REQ ? LIST_REQ_ON : ~LIST_REQ_ON;
  assign gap_done = gap_cnt == GW'(REQ_GAP);
  assign tmo_hit = TIMEOUT != 0 && wait_cnt == TW'(TIMEOUT - 1);
  assign accumulate = state == REQ && list_ack == LIST_ACK_ON && list_eol == LIST_ELEM;
  list_fold_acc #(
    .DATA_WIDTH(DATA_WIDTH),
    .SUM_WIDTH(SUM_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_acc (
    .CLOCK_50(CLOCK_50),
    .RESET_N(RESET_N),
    .clear(state == IDLE),
    .accumulate(accumulate),
    .value(list_value),
    .sum(acc_sum),
    .count(acc_count),
    .max(acc_max)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = start ? REQ : IDLE;
      REQ: nxt = list_ack == LIST_ACK_ON ? (list_eol == LIST_EOL ? FINISH : GAP) : tmo_hit ? FINISH : REQ;
      GAP: nxt = gap_done ? REQ : GAP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      gap_cnt <= '0;
      wait_cnt <= '0;
      aborted <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result_valid <= 1'b0;
      timeout_err <= 1'b0;
      result_sum <= '0;
      result_count <= '0;
      result_max <= '0;
    end else begin
      state <= nxt;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      wait_cnt <= state == REQ ? wait_cnt + 1'b1 : '0;
      aborted <= state == IDLE ? 1'b0 : (state == REQ && !list_ack && tmo_hit) ? 1'b1 : aborted;
      busy <= state == IDLE ? start : state == FINISH ? 1'b0 : busy;
      done <= state == FINISH;
      result_valid <= (state == IDLE && start) ? 1'b0 : state == FINISH ? !aborted : result_valid;
      timeout_err <= (state == IDLE && start) ? 1'b0 : state == FINISH ? aborted : timeout_err;
      result_sum <= state == FINISH ? acc_sum : result_sum;
      result_count <= state == FINISH ? acc_count : result_count;
      result_max <= state == FINISH ? acc_max : result_max;
    end
endmodule

// File: tb/tb_list_fold_sink.sv
// tb_list_fold_sink: randomized producer against a list-level reference model of the fold sink
module tb_list_fold_sink;
  localparam int DW = 8;
  localparam int SW = 16;
  localparam int CW = 8;
  localparam int GAPP = 3;
  localparam int TMO = 16;
  localparam int LIMIT = 5000;
  logic CLOCK_50 = 1'b0;
  logic RESET_N = 1'b0;
  logic start = 1'b0;
  logic list_ack = 1'b0;
  logic list_eol = 1'b0;
  logic [DW-1:0] list_value = '0;
  logic busy, fn_ready, list_req, result_valid, done, timeout_err;
  logic [SW-1:0] result_sum;
  logic [CW-1:0] result_count;
  logic [DW-1:0] result_max;
  list_fold_sink #(
    .DATA_WIDTH(DW), .SUM_WIDTH(SW), .CNT_WIDTH(CW), .REQ_GAP(GAPP), .TIMEOUT(TMO)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start), .busy(busy), .fn_ready(fn_ready),
    .list_req(list_req), .list_ack(list_ack), .list_eol(list_eol), .list_value(list_value),
    .result_sum(result_sum), .result_count(result_count), .result_max(result_max),
    .result_valid(result_valid), .done(done), .timeout_err(timeout_err)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  int n_chk = 0;
  int n_fail = 0;
  byte prod_q[$];
  int lat = 0;
  bit never = 0;
  bit spur = 0;
  int rq = 0;
  always @(negedge CLOCK_50) begin
    list_ack = 1'b0;
    list_eol = 1'b0;
    list_value = 8'($urandom);
    if (list_req) begin
      rq++;
      if (!never && rq > lat) begin
        list_ack = 1'b1;
        list_eol = prod_q.size() == 0;
        if (!list_eol) list_value = prod_q.pop_front();
      end
    end else begin
      rq = 0;
      if (spur && busy) begin
        list_ack = 1'b1;
        list_eol = 1'($urandom_range(0, 1));
      end
    end
  end
  int cyc = 0;
  byte vals[$];
  bit e_busy, e_fn, e_req, e_done, e_valid, e_to, fin, tmo;
  logic [SW-1:0] e_sum;
  logic [CW-1:0] e_cnt;
  logic [DW-1:0] e_max;
  int req_at, waited;
  function automatic logic [SW+CW+DW-1:0] fold();
    int s = 0;
    int mx = -128;
    int c;
    foreach (vals[i]) begin
      s += vals[i];
      if (vals[i] > mx) mx = vals[i];
    end
    c = vals.size() > 255 ? 255 : vals.size();
    return {SW'(s), CW'(c), DW'(mx)};
  endfunction
  always @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      {e_busy, e_fn, e_req, e_done, e_valid, e_to, fin, tmo} = '0;
      {e_sum, e_cnt, e_max} = '0;
      vals.delete();
    end else begin
      e_done = 1'b0;
      if (fin) begin
        fin = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b1;
        e_valid = !tmo;
        e_to = tmo;
        {e_sum, e_cnt, e_max} = fold();
      end else if (!e_busy) begin
        if (start) begin
          e_busy = 1'b1;
          e_valid = 1'b0;
          e_to = 1'b0;
          tmo = 1'b0;
          vals.delete();
          req_at = cyc;
          waited = 0;
        end
      end else if (e_req) begin
        if (list_ack && list_eol) fin = 1'b1;
        else if (list_ack) begin
          vals.push_back(byte'(list_value));
          req_at = cyc + 1 + GAPP;
          waited = 0;
        end else begin
          waited++;
          if (waited == TMO) begin
            fin = 1'b1;
            tmo = 1'b1;
          end
        end
      end
      e_fn = e_busy && !fin;
      e_req = e_fn && cyc >= req_at;
    end
    cyc++;
  end
  int low_len = 0, last_gap = 0, hi_len = 0, last_hi = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    logic [37:0] act, exp;
    @(negedge CLOCK_50);
    act = {busy, fn_ready, list_req, done, result_valid, timeout_err, result_sum, result_count, result_max};
    exp = RESET_N ? {e_busy, e_fn, e_req, e_done, e_valid, e_to, e_sum, e_cnt, e_max} : '0;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cycle %0d outputs {busy,fn,req,done,valid,to,sum,cnt,max}: got %h expected %h", cyc, act, exp);
    end
    if (!RESET_N) {low_len, hi_len} = '0;
    else if (list_req) begin
      if (low_len > 0) last_gap = low_len;
      low_len = 0;
      hi_len++;
    end else begin
      if (hi_len > 0) last_hi = hi_len;
      hi_len = 0;
      if (fn_ready) low_len++;
    end
  endtask
  task automatic run(input int l, input bit nv, input bit sp, input bit st, output int dk);
    lat = l;
    never = nv;
    spur = sp;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("timeout_err_cleared", timeout_err, 0);
    chk("valid_cleared", result_valid, 0);
    dk = 0;
    while (!done && dk < LIMIT) begin
      start = st && busy && $urandom_range(0, 3) == 0;
      tick();
      dk++;
    end
    start = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_wait: got no done within %0d cycles", LIMIT);
    end
  endtask
  initial begin
    int dk, n;
    tick();
    tick();
    chk("reset_outputs", {busy, fn_ready, list_req, done, result_valid, timeout_err, result_sum, result_count, result_max}, 0);
    #1 RESET_N = 1'b1;
    tick();
    prod_q = '{-2, 4, 7};
    run(2, 0, 0, 0, dk);
    chk("t1_sum", $signed(result_sum), 9);
    chk("t1_count", result_count, 3);
    chk("t1_max", $signed(result_max), 7);
    chk("t1_valid", result_valid, 1);
    chk("t1_timeout", timeout_err, 0);
    tick();
    chk("t1_done_single", done, 0);
    prod_q.delete();
    run(0, 0, 0, 0, dk);
    chk("empty_done_latency", dk, 2);
    chk("empty_sum", result_sum, 0);
    chk("empty_count", result_count, 0);
    chk("empty_max", $signed(result_max), -128);
    prod_q = '{1, 2, 3, 4};
    run(0, 0, 1, 0, dk);
    chk("gap_low_cycles", last_gap, 4);
    chk("gap_count", result_count, 4);
    chk("gap_sum", result_sum, 10);
    chk("gap_max", $signed(result_max), 4);
    prod_q.delete();
    run(0, 1, 0, 0, dk);
    chk("tmo_req_high", last_hi, 16);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_valid", result_valid, 0);
    chk("tmo_done_latency", dk, 17);
    for (int i = 0; i < 300; i++) prod_q.push_back(8'sd100);
    run(0, 0, 0, 1, dk);
    chk("sat_count", result_count, 255);
    chk("sat_sum", result_sum, 30000);
    chk("sat_max", $signed(result_max), 100);
    chk("sat_valid", result_valid, 1);
    prod_q = '{-5, -100, -7};
    run(1, 0, 1, 1, dk);
    chk("neg_sum", $signed(result_sum), -112);
    chk("neg_max", $signed(result_max), -5);
    prod_q = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};
    lat = 1;
    never = 0;
    spur = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    #2 RESET_N = 1'b0;
    #1 chk("rst_async_outputs", {busy, fn_ready, list_req, done, result_valid, timeout_err, result_sum, result_count, result_max}, 0);
    repeat (3) tick();
    #1 RESET_N = 1'b1;
    prod_q.delete();
    tick();
    prod_q = '{5, -3, 10};
    run(1, 0, 0, 0, dk);
    chk("post_rst_sum", result_sum, 12);
    chk("post_rst_count", result_count, 3);
    chk("post_rst_max", $signed(result_max), 10);
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(0, 20);
      prod_q.delete();
      for (int i = 0; i < n; i++) prod_q.push_back(byte'($urandom));
      run($urandom_range(0, 3), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dk);
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
